// File: rtl/wb_stage_pkg.sv
// Shared pipeline definitions for the write-back stage: widths, the
// write-back state enum and the MEM/WB pipeline register layout.
package wb_stage_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   // Write-back control state: RUN captures from MEM, HALTED waits for resume.
   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } wb_state_t;

   // MEM/WB pipeline register contents.
   typedef struct packed {
      logic [DATA_W-1:0]     read_data;
      logic [DATA_W-1:0]     alu_result;
      logic [REG_ADDR_W-1:0] rd;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  valid;
      logic                  halt;
   } mem_wb_t;

   // A real, non-HALT instruction: the ones that retire.
   function automatic logic wb_is_retiring(input mem_wb_t e);
      return e.valid & ~e.halt;
   endfunction

   // A retiring instruction that targets a register other than $zero.
   function automatic logic wb_is_writing(input mem_wb_t e);
      return wb_is_retiring(e) & e.reg_write & (e.rd != '0);
   endfunction

   // Write-back value select: load data or ALU result.
   function automatic logic [DATA_W-1:0] wb_select(input mem_wb_t e);
      return e.mem_to_reg ? e.read_data : e.alu_result;
   endfunction

endpackage

// File: rtl/wb_stage_if.sv
// Bus between the MEM stage / debug unit and the write-back stage.
// master = MEM stage + debug unit side, slave = wb_stage.
interface wb_stage_if #(
   parameter int CNT_W = 32
);
   import wb_stage_pkg::*;

   // MEM stage outputs
   logic [DATA_W-1:0]     i_m_wb_read_data;
   logic [DATA_W-1:0]     i_m_wb_alu_result;
   logic [REG_ADDR_W-1:0] i_m_wb_rd;
   logic                  i_m_wb_mem_to_reg;
   logic                  i_m_wb_reg_write;
   logic                  i_m_valid;
   logic                  i_m_halt;

   // Debug unit controls
   logic                  i_du_enable;
   logic                  i_du_resume;
   logic                  i_du_cnt_clear;

   // Register-file write port, forwarding and debug status
   logic [DATA_W-1:0]     o_wb_write_data;
   logic [REG_ADDR_W-1:0] o_wb_rd;
   logic                  o_wb_reg_write;
   logic                  o_wb_halted;
   logic [CNT_W-1:0]      o_wb_retired_count;

   modport master (
      output i_m_wb_read_data, i_m_wb_alu_result, i_m_wb_rd,
             i_m_wb_mem_to_reg, i_m_wb_reg_write, i_m_valid, i_m_halt,
             i_du_enable, i_du_resume, i_du_cnt_clear,
      input  o_wb_write_data, o_wb_rd, o_wb_reg_write, o_wb_halted,
             o_wb_retired_count
   );

   modport slave (
      input  i_m_wb_read_data, i_m_wb_alu_result, i_m_wb_rd,
             i_m_wb_mem_to_reg, i_m_wb_reg_write, i_m_valid, i_m_halt,
             i_du_enable, i_du_resume, i_du_cnt_clear,
      output o_wb_write_data, o_wb_rd, o_wb_reg_write, o_wb_halted,
             o_wb_retired_count
   );

endinterface

// File: rtl/wb_retire_counter.sv
// Saturating retired-instruction counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module wb_retire_counter #(
   parameter int CNT_W = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear first, otherwise increment unless already saturated.
   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = '0;
      end else if (i_inc && (count_q != '1)) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back mux, register-file
// write enable, RUN/HALTED debug state machine and retired counter.
// Optional feature: define WB_RETIRE_CNT_EN to build the retired counter;
// without it o_wb_retired_count reads 0 and i_du_cnt_clear is ignored.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic      i_clk,
   input  logic      i_reset,
   wb_stage_if.slave bus
);

   wb_state_t  state_q;
   wb_state_t  state_d;
   mem_wb_t    entry_q;
   mem_wb_t    entry_d;
   mem_wb_t    entry_in;
   logic       fresh_q;
   logic       fresh_d;
   logic       cap;
   logic       retire;
   logic [CNT_W-1:0] retired_count;

   // Pack the MEM outputs into the pipeline register layout.
   always_comb begin
      entry_in            = '0;
      entry_in.read_data  = bus.i_m_wb_read_data;
      entry_in.alu_result = bus.i_m_wb_alu_result;
      entry_in.rd         = bus.i_m_wb_rd;
      entry_in.mem_to_reg = bus.i_m_wb_mem_to_reg;
      entry_in.reg_write  = bus.i_m_wb_reg_write;
      entry_in.valid      = bus.i_m_valid;
      entry_in.halt       = bus.i_m_halt;
   end

   // The stage only advances while running and the debug unit allows it.
   assign cap = bus.i_du_enable & (state_q == RUN);

   // Pipeline register next state: load on capture, otherwise hold. The
   // fresh flag marks the single cycle in which an entry may act.
   always_comb begin
      entry_d = entry_q;
      fresh_d = 1'b0;
      if (cap) begin
         entry_d = entry_in;
         fresh_d = 1'b1;
      end
   end

   // Halt FSM next state: a fresh HALT entry stops the stage, resume restarts
   // it. The transition looks only at fresh, not at the current enable.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (fresh_q && entry_q.valid && entry_q.halt) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            if (bus.i_du_resume) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Halt FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // MEM/WB pipeline register and its fresh flag.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         entry_q <= '0;
         fresh_q <= 1'b0;
      end else begin
         entry_q <= entry_d;
         fresh_q <= fresh_d;
      end
   end

   // A held entry was already written and counted in its fresh cycle.
   assign retire = fresh_q & wb_is_retiring(entry_q);

   assign bus.o_wb_write_data = wb_select(entry_q);
   assign bus.o_wb_rd         = entry_q.rd;
   assign bus.o_wb_reg_write  = fresh_q & wb_is_writing(entry_q);
   assign bus.o_wb_halted     = (state_q == HALTED);

`ifdef WB_RETIRE_CNT_EN
   wb_retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (bus.i_du_cnt_clear),
      .i_inc   (retire),
      .o_count (retired_count)
   );
`else
   logic unused_cnt_inputs;
   assign unused_cnt_inputs = bus.i_du_cnt_clear ^ retire;
   assign retired_count     = '0;
`endif

   assign bus.o_wb_retired_count = retired_count;

endmodule
